// File: rtl/call_stack_controller_pkg.sv
// call_stack_controller_pkg: shared command/state encodings and stack defaults
package call_stack_controller_pkg;

    typedef enum logic [1:0] {
        CTL_NOP  = 2'd0,
        CTL_PUSH = 2'd1,
        CTL_POP  = 2'd2,
        CTL_RET  = 2'd3
    } stack_ctl_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CAPTURE,
        S_RESP,
        S_ERR
    } state_e;

    localparam logic [7:0] DEFAULT_STACK_TOP = 8'hFF;

endpackage

// File: rtl/call_stack_controller_stack_pointer.sv
// stack_pointer: downward-growing sp with entry count and full/empty flags
module stack_pointer
    import call_stack_controller_pkg::*;
#(
    parameter logic [7:0] STACK_TOP   = DEFAULT_STACK_TOP,
    parameter int         STACK_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] sp,
    output logic       full,
    output logic       empty
);

    localparam logic [7:0] DEPTH = 8'(STACK_DEPTH);

    logic [7:0] count;

    assign full  = count == DEPTH;
    assign empty = count == 8'd0;

    // bounds are enforced by count only; sp is free to wrap modulo 256
    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= STACK_TOP;
            count <= 8'd0;
        end else if (inc) begin
            sp    <= sp - 8'd1;
            count <= count + 8'd1;
        end else if (dec) begin
            sp    <= sp + 8'd1;
            count <= count - 8'd1;
        end
    end

endmodule

// File: rtl/call_stack_controller.sv
// call_stack_controller: PUSH/POP/RET sequencer over a data-memory stack
module call_stack_controller
    import call_stack_controller_pkg::*;
#(
    parameter logic [7:0] STACK_TOP   = DEFAULT_STACK_TOP,
    parameter int         STACK_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] stack_ctl,
    input  logic       cmd_valid,
    input  logic [7:0] push_data,
    input  logic [7:0] data_mem_val,
    output logic       busy,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       mem_re,
    output logic [7:0] pop_data,
    output logic       pop_valid,
    output logic [7:0] jump_address,
    output logic       jump_valid,
    output logic [7:0] sp,
    output logic       overflow,
    output logic       underflow
);

    state_e     state, state_n;
    stack_ctl_e cmd_q;
    logic [7:0] data_q;
    logic       full, empty, accept, is_push;

    assign is_push = stack_ctl_e'(stack_ctl) == CTL_PUSH;
    assign accept  = state == S_IDLE && cmd_valid && stack_ctl_e'(stack_ctl) != CTL_NOP;

    stack_pointer #(
        .STACK_TOP  (STACK_TOP),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_sp (
        .clk  (clk),
        .rst  (rst),
        .inc  (state == S_WRITE),
        .dec  (state == S_CAPTURE),
        .sp   (sp),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = S_IDLE;
        case (state)
            S_IDLE:    state_n = !accept ? S_IDLE :
                                 is_push ? (full ? S_ERR : S_WRITE) :
                                           (empty ? S_ERR : S_READ);
            S_READ:    state_n = S_CAPTURE;
            S_CAPTURE: state_n = S_RESP;
            default:   state_n = S_IDLE;
        endcase
    end

    assign busy       = state != S_IDLE;
    assign mem_we     = state == S_WRITE;
    assign mem_re     = state == S_READ;
    assign mem_addr   = mem_we ? sp : mem_re ? sp + 8'd1 : 8'd0;
    assign mem_wdata  = mem_we ? data_q : 8'd0;
    assign pop_valid  = state == S_RESP && cmd_q == CTL_POP;
    assign jump_valid = state == S_RESP && cmd_q == CTL_RET;

    // read data arrives during CAPTURE; registering it here makes it visible in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q        <= CTL_NOP;
            data_q       <= 8'd0;
            pop_data     <= 8'd0;
            jump_address <= 8'd0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q     <= stack_ctl_e'(stack_ctl);
                data_q    <= push_data;
                overflow  <= overflow | (is_push && full);
                underflow <= underflow | (!is_push && empty);
            end
            if (state == S_CAPTURE && cmd_q == CTL_POP) pop_data <= data_mem_val;
            if (state == S_CAPTURE && cmd_q == CTL_RET) jump_address <= data_mem_val;
        end
    end

endmodule

// File: tb/tb_call_stack_controller.sv
// tb_call_stack_controller: directed checks of the call stack sequencer
module tb_call_stack_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] stack_ctl = 2'd0;
    logic       cmd_valid = 1'b0;
    logic [7:0] push_data = 8'd0;
    logic [7:0] data_mem_val = 8'd0;
    logic       busy, mem_we, mem_re, pop_valid, jump_valid, overflow, underflow;
    logic [7:0] mem_addr, mem_wdata, pop_data, jump_address, sp;

    logic [7:0] mem [256];
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         base_we, base_re;

    call_stack_controller dut (
        .clk         (clk),
        .rst         (rst),
        .stack_ctl   (stack_ctl),
        .cmd_valid   (cmd_valid),
        .push_data   (push_data),
        .data_mem_val(data_mem_val),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .jump_address(jump_address),
        .jump_valid  (jump_valid),
        .sp          (sp),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) data_mem_val <= mem[mem_addr];
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_re) re_cnt <= re_cnt + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [1:0] ctl, input logic [7:0] d);
        stack_ctl = ctl;
        push_data = d;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_sp", sp, 8'hFF);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_popv", pop_valid, 0);

        issue(2'd1, 8'h42);
        chk("push_we", mem_we, 1);
        chk("push_addr", mem_addr, 8'hFF);
        chk("push_wdata", mem_wdata, 8'h42);
        chk("push_busy", busy, 1);
        cyc();
        chk("push_we_off", mem_we, 0);
        chk("push_sp", sp, 8'hFE);
        chk("push_idle", busy, 0);

        do_reset();
        issue(2'd1, 8'h10);
        cyc();
        issue(2'd3, 8'h00);
        chk("ret_re", mem_re, 1);
        chk("ret_addr", mem_addr, 8'hFF);
        chk("ret_we", mem_we, 0);
        cyc();
        chk("ret_cap_jv", jump_valid, 0);
        chk("ret_cap_re", mem_re, 0);
        cyc();
        chk("ret_jv", jump_valid, 1);
        chk("ret_ja", jump_address, 8'h10);
        chk("ret_popv", pop_valid, 0);
        chk("ret_sp", sp, 8'hFF);
        cyc();
        chk("ret_jv_off", jump_valid, 0);
        chk("ret_ja_hold", jump_address, 8'h10);
        chk("ret_idle", busy, 0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue(2'd1, 8'(i));
            cyc();
        end
        chk("fill_sp", sp, 8'hEF);
        chk("fill_ovf", overflow, 0);
        base_we = we_cnt;
        issue(2'd1, 8'hEE);
        chk("ovf_busy", busy, 1);
        chk("ovf_we", mem_we, 0);
        chk("ovf_flag", overflow, 1);
        cyc();
        chk("ovf_idle", busy, 0);
        chk("ovf_sp", sp, 8'hEF);
        chk("ovf_nowrite", we_cnt - base_we, 0);
        issue(2'd2, 8'h00);
        cyc();
        cyc();
        chk("full_pop_v", pop_valid, 1);
        chk("full_pop_d", pop_data, 8'h0F);
        cyc();
        chk("full_pop_sp", sp, 8'hF0);
        chk("ovf_sticky", overflow, 1);

        do_reset();
        chk("ovf_cleared", overflow, 0);
        base_re = re_cnt;
        issue(2'd2, 8'h00);
        chk("unf_busy", busy, 1);
        chk("unf_re", mem_re, 0);
        chk("unf_flag", underflow, 1);
        chk("unf_popv", pop_valid, 0);
        cyc();
        chk("unf_idle", busy, 0);
        chk("unf_popv2", pop_valid, 0);
        chk("unf_sp", sp, 8'hFF);
        chk("unf_noread", re_cnt - base_re, 0);
        cyc();
        chk("unf_sticky", underflow, 1);

        do_reset();
        issue(2'd1, 8'hAA);
        cyc();
        base_we = we_cnt;
        stack_ctl = 2'd2;
        cmd_valid = 1'b1;
        cyc();
        stack_ctl = 2'd1;
        push_data = 8'h55;
        chk("busy_read", mem_re, 1);
        cyc();
        chk("busy_cap_we", mem_we, 0);
        cyc();
        chk("busy_resp_v", pop_valid, 1);
        chk("busy_resp_d", pop_data, 8'hAA);
        chk("busy_resp_we", mem_we, 0);
        cyc();
        chk("busy_idle", busy, 0);
        chk("busy_nowrite", we_cnt - base_we, 0);
        cyc();
        cmd_valid = 1'b0;
        chk("late_we", mem_we, 1);
        chk("late_wdata", mem_wdata, 8'h55);
        chk("late_addr", mem_addr, 8'hFF);
        cyc();
        chk("late_one", we_cnt - base_we, 1);
        chk("late_sp", sp, 8'hFE);

        do_reset();
        issue(2'd1, 8'h77);
        cyc();
        issue(2'd2, 8'h00);
        cyc();
        base_re = re_cnt;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_popv", pop_valid, 0);
        chk("abort_sp", sp, 8'hFF);
        chk("abort_busy", busy, 0);
        chk("abort_re", mem_re, 0);
        cyc();
        chk("abort_popv2", pop_valid, 0);
        chk("abort_popd", pop_data, 0);
        chk("abort_noread", re_cnt - base_re, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
